// File: rtl/biquad_sequencer.sv
// Cascade of Q2.14 biquads sharing one multiplier and one 35-bit accumulator.
// Define BIQUAD_SEQ_SAT_EN to clamp the quantizer; otherwise it wraps.
module biquad_sequencer #(
    parameter int NUM_STAGES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_valid,
    input  logic [15:0] sample_in,
    input  logic        coef_we,
    input  logic [5:0]  coef_addr,
    input  logic [15:0] coef_data,
    input  logic        coef_commit,
    input  logic        overrun_clr,
    output logic [15:0] sample_out,
    output logic        out_valid,
    output logic        busy,
    output logic        overrun
);
    localparam int NC = NUM_STAGES * 5;
    localparam int CW = $clog2(NC);
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, WB} state_t;

    state_t             state_q;
    logic [2:0]         k_q;
    logic [SW-1:0]      stg_q;
    logic signed [15:0] shadow_q [NC];
    logic signed [15:0] active_q [NC];
    logic signed [15:0] x1_q [NUM_STAGES];
    logic signed [15:0] x2_q [NUM_STAGES];
    logic signed [15:0] y1_q [NUM_STAGES];
    logic signed [15:0] y2_q [NUM_STAGES];
    logic signed [15:0] xin_q;
    logic signed [31:0] prod_q;
    logic               neg_q;
    logic signed [34:0] acc_q;
    logic               pend_q;
    logic               copy_q;
    logic [15:0]        sample_out_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               overrun_q;

    logic [CW-1:0]      cidx;
    logic [CW-1:0]      widx;
    logic               wok;
    logic               last;
    logic               accept;
    logic signed [15:0] cf;
    logic signed [15:0] dt;
    logic signed [15:0] yq;

    always_comb begin
        cidx   = CW'(32'(stg_q) * 5 + 32'(k_q));
        widx   = CW'(32'(coef_addr[5:3]) * 5 + 32'(coef_addr[2:0]));
        wok    = coef_we && (32'(coef_addr[5:3]) < NUM_STAGES)
                 && (coef_addr[2:0] < 3'd5);
        last   = (stg_q == SW'(NUM_STAGES - 1));
        // The final WB may take a new strobe so back-to-back samples never overrun.
        accept = sample_valid
                 && ((state_q == IDLE) || ((state_q == WB) && last));
        cf     = active_q[cidx];
        unique case (k_q)
            3'd0:    dt = xin_q;
            3'd1:    dt = x1_q[stg_q];
            3'd2:    dt = x2_q[stg_q];
            3'd3:    dt = y1_q[stg_q];
            default: dt = y2_q[stg_q];
        endcase
    end

`ifdef BIQUAD_SEQ_SAT_EN
    logic signed [20:0] ysh;
    always_comb begin
        ysh = acc_q[34:14];
        if (ysh > 21'sd32767)
            yq = 16'sh7fff;
        else if (ysh < -21'sd32768)
            yq = 16'sh8000;
        else
            yq = ysh[15:0];
    end
`else
    assign yq = acc_q[29:14];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            stg_q        <= '0;
            xin_q        <= '0;
            prod_q       <= '0;
            neg_q        <= 1'b0;
            acc_q        <= '0;
            pend_q       <= 1'b0;
            copy_q       <= 1'b0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NC; i++) begin
                shadow_q[i] <= (i % 5 == 0) ? 16'sd16384 : 16'sd0;
                active_q[i] <= (i % 5 == 0) ? 16'sd16384 : 16'sd0;
            end
            for (int s = 0; s < NUM_STAGES; s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (wok)
                shadow_q[widx] <= coef_data;
            if (accept) begin
                pend_q <= 1'b0;
                copy_q <= pend_q | coef_commit;
            end else if (coef_commit) begin
                pend_q <= 1'b1;
            end
            if (sample_valid && !accept)
                overrun_q <= 1'b1;
            else if (overrun_clr)
                overrun_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        xin_q   <= sample_in;
                        stg_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (copy_q)
                        for (int i = 0; i < NC; i++)
                            active_q[i] <= shadow_q[i];
                    k_q     <= '0;
                    state_q <= MAC;
                end
                MAC: begin
                    prod_q <= cf * dt;
                    neg_q  <= (k_q >= 3'd3);
                    if (k_q == 3'd0)
                        acc_q <= '0;
                    else if (neg_q)
                        acc_q <= acc_q - 35'(prod_q);
                    else
                        acc_q <= acc_q + 35'(prod_q);
                    if (k_q == 3'd4)
                        state_q <= DRAIN;
                    else
                        k_q <= k_q + 3'd1;
                end
                DRAIN: begin
                    if (neg_q)
                        acc_q <= acc_q - 35'(prod_q);
                    else
                        acc_q <= acc_q + 35'(prod_q);
                    state_q <= WB;
                end
                WB: begin
                    x2_q[stg_q] <= x1_q[stg_q];
                    x1_q[stg_q] <= xin_q;
                    y2_q[stg_q] <= y1_q[stg_q];
                    y1_q[stg_q] <= yq;
                    xin_q       <= yq;
                    k_q         <= '0;
                    if (last) begin
                        sample_out_q <= yq;
                        out_valid_q  <= 1'b1;
                        if (accept) begin
                            xin_q   <= sample_in;
                            stg_q   <= '0;
                            state_q <= LOAD;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        stg_q   <= stg_q + SW'(1);
                        state_q <= MAC;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_biquad_sequencer.sv
// Scoreboard bench for biquad_sequencer: a per-sample difference-equation
// model predicts outputs and their arrival edge; a monitor pops and compares.
module tb_biquad_sequencer;
    localparam int NS   = 3;
    localparam int SPAN = 7 * NS + 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = '0;
    logic        coef_we = 1'b0;
    logic [5:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        coef_commit = 1'b0;
    logic        overrun_clr = 1'b0;
    logic [15:0] sample_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    biquad_sequencer #(.NUM_STAGES(NS)) dut (
        .clk(clk), .reset_n(reset_n),
        .sample_valid(sample_valid), .sample_in(sample_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_commit(coef_commit), .overrun_clr(overrun_clr),
        .sample_out(sample_out), .out_valid(out_valid),
        .busy(busy), .overrun(overrun)
    );

    typedef struct packed {
        int val;
        int due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   last_acc = -1000;
    bit   started = 1'b0;
    bit   m_ovr;
    bit   m_pend;
    int   sh [NS][5];
    int   ac [NS][5];
    int   hx1 [NS];
    int   hx2 [NS];
    int   hy1 [NS];
    int   hy2 [NS];

    function automatic void m_reset();
        for (int s = 0; s < NS; s++) begin
            for (int j = 0; j < 5; j++) begin
                sh[s][j] = (j == 0) ? 16384 : 0;
                ac[s][j] = (j == 0) ? 16384 : 0;
            end
            hx1[s] = 0; hx2[s] = 0; hy1[s] = 0; hy2[s] = 0;
        end
        m_ovr = 0;
        m_pend = 0;
        last_acc = -1000;
        q.delete();
    endfunction

    function automatic int quant(longint a);
        longint v;
        logic signed [15:0] w;
        v = a >>> 14;
`ifdef BIQUAD_SEQ_SAT_EN
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`endif
        w = 16'(v);
        return int'(w);
    endfunction

    function automatic void model_accept(int x);
        longint a;
        int y;
        for (int s = 0; s < NS; s++) begin
            a = longint'(ac[s][0]) * x + longint'(ac[s][1]) * hx1[s]
              + longint'(ac[s][2]) * hx2[s] - longint'(ac[s][3]) * hy1[s]
              - longint'(ac[s][4]) * hy2[s];
            y = quant(a);
            hx2[s] = hx1[s]; hx1[s] = x;
            hy2[s] = hy1[s]; hy1[s] = y;
            x = y;
        end
        q.push_back('{val: x, due: edge_n + SPAN});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit v, input int smp, input bit we,
                        input int addr, input int data, input bit cm,
                        input bit clr);
        logic [5:0] a6;
        logic signed [15:0] d16;
        logic signed [15:0] s16;
        bit acc;
        a6 = 6'(addr);
        d16 = 16'(data);
        s16 = 16'(smp);
        sample_valid = v; sample_in = s16; coef_we = we;
        coef_addr = a6; coef_data = d16; coef_commit = cm;
        overrun_clr = clr;
        @(posedge clk);
        edge_n++;
        if (reset_n) begin
            if (we && int'(a6[5:3]) < NS && a6[2:0] < 3'd5)
                sh[a6[5:3]][a6[2:0]] = int'(d16);
            acc = v && (edge_n - last_acc >= SPAN);
            if (acc) begin
                if (m_pend || cm) ac = sh;
                m_pend = 0;
                last_acc = edge_n;
                model_accept(int'(s16));
            end else if (cm) begin
                m_pend = 1;
            end
            if (v && !acc) m_ovr = 1;
            else if (clr) m_ovr = 0;
        end
        #1;
        sample_valid = 0; coef_we = 0; coef_commit = 0; overrun_clr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send(input int x);
        step(1, x, 0, 0, 0, 0, 0);
        idle(SPAN);
    endtask

    task automatic wr(input int s, input int sel, input int d, input bit cm);
        step(0, 0, 1, s * 8 + sel, d, cm, 0);
    endtask

    task automatic do_reset();
        reset_n = 0;
        m_reset();
        idle(2);
        reset_n = 1;
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("busy", int'(busy), int'(reset_n && (edge_n - last_acc < SPAN)));
            chk("overrun", int'(overrun), int'(m_ovr));
            if (q.size() > 0 && edge_n > q[0].due) begin
                chk("missing_out_due", edge_n, q[0].due);
                void'(q.pop_front());
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", int'($signed(sample_out)), -99999);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_value", int'($signed(sample_out)), e.val);
                    chk("out_edge", edge_n, e.due);
                end
            end
        end
    end

    initial begin
        m_reset();
        #1;
        reset_n = 0;
        started = 1;
        idle(2);
        reset_n = 1;
        chk("rst_out", int'(sample_out), 0);
        chk("rst_valid", int'(out_valid), 0);

        send(1000);
        chk("unity", int'($signed(sample_out)), 1000);

        wr(0, 0, 8192, 0);
        send(1000);
        chk("no_commit", int'($signed(sample_out)), 1000);
        step(0, 0, 0, 0, 0, 1, 0);
        send(1000);
        chk("committed_gain", int'($signed(sample_out)), 500);

        do_reset();
        wr(0, 3, -8192, 1);
        send(16384);
        chk("rec0", int'($signed(sample_out)), 16384);
        send(0);
        chk("rec1", int'($signed(sample_out)), 8192);
        send(0);
        chk("rec2", int'($signed(sample_out)), 4096);
        send(0);
        chk("rec3", int'($signed(sample_out)), 2048);

        do_reset();
        wr(0, 3, -8192, 1);
        send(0);
        chk("hist_cleared", int'($signed(sample_out)), 0);

        step(1, 777, 0, 0, 0, 0, 0);
        idle(4);
        step(1, 555, 0, 0, 0, 0, 0);
        idle(SPAN);
        chk("ovr_out", int'($signed(sample_out)), 777);
        chk("ovr_set", int'(overrun), 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("ovr_clr", int'(overrun), 0);

        wr(0, 3, 0, 0);
        wr(0, 0, 32767, 1);
        send(30000);
`ifdef BIQUAD_SEQ_SAT_EN
        chk("sat", int'($signed(sample_out)), 32767);
`else
        chk("wrap", int'($signed(sample_out)), -5538);
`endif

        step(1, 2222, 0, 0, 0, 0, 0);
        idle(9);
        do_reset();
        idle(SPAN);
        send(1234);
        chk("after_mid_reset", int'($signed(sample_out)), 1234);

        step(1, 300, 0, 0, 0, 0, 0);
        idle(SPAN - 1);
        step(1, -300, 0, 0, 0, 0, 0);
        idle(SPAN);
        chk("b2b_no_ovr", int'(overrun), 0);

        for (int i = 0; i < 2500; i++) begin
            bit v, we, cm, clr;
            v   = ($urandom_range(0, 14) == 0);
            we  = ($urandom_range(0, 5) == 0);
            cm  = ($urandom_range(0, 19) == 0) && (edge_n != last_acc);
            clr = ($urandom_range(0, 29) == 0);
            step(v, int'($urandom_range(0, 65535)) - 32768, we,
                 int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 32767)) - 16384, cm, clr);
        end
        idle(SPAN + 4);
        chk("drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
